regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU/load) write-back arbiter in front of the register file, with hazard query.
// Optional forwarding of the output stage is enabled by defining RF_ARB_FWD_EN.
module regfile_wb_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_Valid,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  input  logic        B_Valid,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  output logic        A_Ready,
  output logic        B_Ready,
  output logic        RegWre,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  input  logic [4:0]  QueryReg1,
  input  logic [4:0]  QueryReg2,
  output logic        Busy1,
  output logic        Busy2,
  output logic        FwdHit1,
  output logic        FwdHit2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2
);

  typedef enum logic [1:0] {ORD_TIE, ORD_A_OLD, ORD_B_OLD} ord_e;
  typedef enum logic {RR_A, RR_B} rr_e;

  logic        a_v_q, a_v_d, b_v_q, b_v_d;
  logic [4:0]  a_reg_q, a_reg_d, b_reg_q, b_reg_d;
  logic [31:0] a_data_q, a_data_d, b_data_q, b_data_d;
  ord_e        ord_q, ord_d;
  rr_e         rr_q, rr_d;
  logic        rw_q, rw_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] wd_q, wd_d;

  logic        gnt_a, gnt_b, acc_a, acc_b;
  logic [4:0]  g_reg;
  logic [31:0] g_data;

  // Older slot wins; a tie means both were loaded on the same edge, resolved round-robin.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (a_v_q && b_v_q) begin
      unique case (ord_q)
        ORD_A_OLD: gnt_a = 1'b1;
        ORD_B_OLD: gnt_b = 1'b1;
        default: begin
          if (rr_q == RR_A) gnt_a = 1'b1;
          else              gnt_b = 1'b1;
        end
      endcase
    end else if (a_v_q) begin
      gnt_a = 1'b1;
    end else if (b_v_q) begin
      gnt_b = 1'b1;
    end
  end

  assign A_Ready = RST & (~a_v_q | gnt_a);
  assign B_Ready = RST & (~b_v_q | gnt_b);
  assign acc_a   = A_Valid & A_Ready;
  assign acc_b   = B_Valid & B_Ready;
  assign g_reg   = gnt_a ? a_reg_q  : b_reg_q;
  assign g_data  = gnt_a ? a_data_q : b_data_q;

  always_comb begin
    a_v_d    = (a_v_q & ~gnt_a) | acc_a;
    b_v_d    = (b_v_q & ~gnt_b) | acc_b;
    a_reg_d  = acc_a ? A_Reg  : a_reg_q;
    a_data_d = acc_a ? A_Data : a_data_q;
    b_reg_d  = acc_b ? B_Reg  : b_reg_q;
    b_data_d = acc_b ? B_Data : b_data_q;

    // A newly accepted entry is always younger than one left waiting in the other slot.
    ord_d = ORD_TIE;
    if (acc_a && acc_b)
      ord_d = ORD_TIE;
    else if (acc_a)
      ord_d = b_v_d ? ORD_B_OLD : ORD_TIE;
    else if (acc_b)
      ord_d = a_v_d ? ORD_A_OLD : ORD_TIE;
    else if (a_v_d && b_v_d)
      ord_d = ord_q;

    rr_d = rr_q;
    if (gnt_a)      rr_d = RR_B;
    else if (gnt_b) rr_d = RR_A;

    // Register-0 grants free the slot without a write pulse.
    rw_d = (gnt_a | gnt_b) && (g_reg != 5'd0);
    wr_d = rw_d ? g_reg  : wr_q;
    wd_d = rw_d ? g_data : wd_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_v_q    <= 1'b0;
      b_v_q    <= 1'b0;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      ord_q    <= ORD_TIE;
      rr_q     <= RR_A;
      rw_q     <= 1'b0;
      wr_q     <= '0;
      wd_q     <= '0;
    end else begin
      a_v_q    <= a_v_d;
      b_v_q    <= b_v_d;
      a_reg_q  <= a_reg_d;
      b_reg_q  <= b_reg_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      ord_q    <= ord_d;
      rr_q     <= rr_d;
      rw_q     <= rw_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
    end
  end

  assign RegWre    = rw_q;
  assign WriteReg  = wr_q;
  assign WriteData = wd_q;

  assign Busy1 = (QueryReg1 != 5'd0) &&
                 ((a_v_q && a_reg_q == QueryReg1) || (b_v_q && b_reg_q == QueryReg1) ||
                  (rw_q && wr_q == QueryReg1));
  assign Busy2 = (QueryReg2 != 5'd0) &&
                 ((a_v_q && a_reg_q == QueryReg2) || (b_v_q && b_reg_q == QueryReg2) ||
                  (rw_q && wr_q == QueryReg2));

`ifdef RF_ARB_FWD_EN
  assign FwdHit1  = rw_q && (wr_q != 5'd0) && (wr_q == QueryReg1);
  assign FwdHit2  = rw_q && (wr_q != 5'd0) && (wr_q == QueryReg2);
  assign FwdData1 = FwdHit1 ? wd_q : '0;
  assign FwdData2 = FwdHit2 ? wd_q : '0;
`else
  assign FwdHit1  = 1'b0;
  assign FwdHit2  = 1'b0;
  assign FwdData1 = '0;
  assign FwdData2 = '0;
`endif

endmodule
